mac_accumulate_stage: RTL and testbench

Accumulation stage of the 16-bit low-power MAC. It sits directly downstream of the Vedic multiplier array and consumes its unsigned 32-bit products. It registers each product, adds it into a saturating wide accumulator, and presents the frame sum after FRAME_LEN products under a valid/ready handshake. Registers load only on qualified events, so there is no switching activity while the stage is idle.

---
 rtl/mac_accumulate_stage_if.sv | 26 ++
 rtl/mac_accumulate_stage.sv | 96 +++++++++
 tb/tb_mac_accumulate_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulate_stage_if.sv
// Product/result handshake bundle for the MAC accumulation stage.
// The master side feeds products and consumes frame sums.
interface mac_accumulate_stage_if #(
  parameter int PW = 32,
  parameter int AW = 40
);
  logic [PW-1:0] p_in;
  logic          p_valid;
  logic          p_ready;
  logic          clr;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready;
  logic          ovf;
  logic          busy;

  modport master (
    output p_in, p_valid, clr, acc_ready,
    input  p_ready, acc_out, acc_valid, ovf, busy
  );

  modport slave (
    input  p_in, p_valid, clr, acc_ready,
    output p_ready, acc_out, acc_valid, ovf, busy
  );
endinterface

// File: rtl/mac_accumulate_stage.sv
// Saturating frame accumulator behind the Vedic multiplier array.
// Registers load only on qualified events to keep the idle stage quiet.
module mac_accumulate_stage #(
  parameter int FRAME_LEN = 16,
  parameter int PW        = 32,
  parameter int AW        = 40
) (
  input  logic clk,
  input  logic rst,
  mac_accumulate_stage_if.slave bus
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [PW-1:0] pipe_reg;
  logic          pipe_v;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          ovf;
  logic          accept;
  logic [AW:0]   sum;

  assign bus.p_ready   = (state == ACCUM) && !bus.clr;
  assign accept        = bus.p_valid && bus.p_ready;
  // One extra bit catches the carry that triggers saturation.
  assign sum           = {1'b0, acc} + (AW+1)'(pipe_reg);
  assign bus.acc_out   = acc_out;
  assign bus.acc_valid = acc_valid;
  assign bus.ovf       = ovf;
  assign bus.busy      = (in_cnt != '0) || (state != ACCUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      in_cnt    <= '0;
      pipe_reg  <= '0;
      pipe_v    <= 1'b0;
      acc       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (bus.clr) begin
      state     <= ACCUM;
      in_cnt    <= '0;
      pipe_v    <= 1'b0;
      acc       <= '0;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      pipe_v <= accept;
      if (accept) pipe_reg <= bus.p_in;
      if (pipe_v) begin
        if (sum[AW]) begin
          acc <= '1;
          ovf <= 1'b1;
        end else begin
          acc <= sum[AW-1:0];
        end
      end
      unique case (state)
        ACCUM: begin
          if (accept) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == LAST) state <= DRAIN;
          end
        end
        DRAIN: state <= DONE;
        DONE: begin
          // First DONE cycle captures the settled sum; release waits for it.
          if (!acc_valid) begin
            acc_out   <= acc;
            acc_valid <= 1'b1;
          end else if (bus.acc_ready) begin
            state     <= ACCUM;
            in_cnt    <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            acc_valid <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Randomized and directed bench for mac_accumulate_stage.
// An event-level frame model predicts every output each cycle.
module tb_mac_accumulate_stage;

  localparam int FL = 4;
  localparam int PW = 32;
  localparam int AW = 33;
  localparam logic [63:0] MAX = (64'd1 << AW) - 1;

  logic clk = 1'b1;
  logic rst;

  always #5 clk = ~clk;

  mac_accumulate_stage_if #(.PW(PW), .AW(AW)) bus ();

  mac_accumulate_stage #(
    .FRAME_LEN(FL),
    .PW(PW),
    .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          cnt = 0;
  int          tmr = 0;
  logic [63:0] sum = '0;
  bit          sat = 1'b0;
  bit          ov = 1'b0;
  logic [63:0] oval = '0;
  bit          oovf = 1'b0;
  bit          armed = 1'b0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model(bit r, bit c, bit pv,
                       logic [31:0] p, bit ar);
    if (r) begin
      cnt = 0; sum = '0; sat = 0; ov = 0;
      oval = '0; oovf = 0; tmr = 0; armed = 1;
    end else if (c) begin
      cnt = 0; sum = '0; sat = 0; ov = 0; tmr = 0;
    end else if (ov) begin
      if (ar) begin
        ov = 0; cnt = 0; sum = '0; sat = 0;
      end
    end else if (cnt == FL) begin
      tmr++;
      if (tmr == 2) begin
        ov = 1; oval = sum; oovf = sat;
      end
    end else if (pv) begin
      sum = sum + 64'(p);
      if (sum > MAX) begin
        sum = MAX; sat = 1;
      end
      cnt++;
      tmr = 0;
    end
  endtask

  task automatic cycle(bit r, bit c, bit pv,
                       logic [31:0] p, bit ar);
    rst = r;
    bus.clr = c;
    bus.p_valid = pv;
    bus.p_in = p;
    bus.acc_ready = ar;
    @(negedge clk);
    if (armed) begin
      chk("acc_valid", 64'(bus.acc_valid), 64'(ov));
      chk("acc_out", 64'(bus.acc_out), oval);
      chk("busy", 64'(bus.busy), 64'(cnt != 0));
      chk("p_ready", 64'(bus.p_ready),
          64'(!c && cnt < FL));
      if (ov || cnt == 0)
        chk("ovf", 64'(bus.ovf), 64'(ov && oovf));
    end
    @(posedge clk);
    model(r, c, pv, p, ar);
    #1;
  endtask

  task automatic feed(logic [31:0] p);
    cycle(0, 0, 1, p, 1);
  endtask

  task automatic idle(bit ar);
    cycle(0, 0, 0, '0, ar);
  endtask

  task automatic lit_reset(string tag);
    chk({tag, "_acc_out"}, 64'(bus.acc_out), 64'd0);
    chk({tag, "_acc_valid"}, 64'(bus.acc_valid), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_p_ready"}, 64'(bus.p_ready), 64'd1);
  endtask

  initial begin
    cycle(1, 0, 0, '0, 0);
    lit_reset("rst0");

    for (int k = 1; k <= 4; k++) feed(32'(k));
    idle(1);
    chk("b2b_early", 64'(bus.acc_valid), 64'd0);
    idle(1);
    chk("b2b_valid", 64'(bus.acc_valid), 64'd1);
    chk("b2b_sum", 64'(bus.acc_out), 64'd10);
    chk("b2b_ovf", 64'(bus.ovf), 64'd0);
    idle(1);
    chk("b2b_rel", 64'(bus.acc_valid), 64'd0);
    chk("b2b_rdy", 64'(bus.p_ready), 64'd1);

    for (int k = 0; k < 4; k++) feed(32'hFFFF_FFFF);
    idle(1);
    idle(1);
    chk("sat_sum", 64'(bus.acc_out), 64'h1_FFFF_FFFF);
    chk("sat_ovf", 64'(bus.ovf), 64'd1);
    idle(1);
    chk("sat_clr_ovf", 64'(bus.ovf), 64'd0);

    for (int k = 0; k < 4; k++) feed(32'd2);
    idle(0);
    idle(0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 1, 32'd9, 0);
      chk("bp_valid", 64'(bus.acc_valid), 64'd1);
      chk("bp_sum", 64'(bus.acc_out), 64'd8);
      chk("bp_rdy", 64'(bus.p_ready), 64'd0);
    end
    idle(1);
    for (int k = 0; k < 4; k++) feed(32'd1);
    idle(1);
    idle(1);
    chk("bp_next", 64'(bus.acc_out), 64'd4);
    idle(1);

    feed(32'd7);
    feed(32'd7);
    cycle(0, 1, 1, 32'd9, 1);
    for (int k = 0; k < 4; k++) feed(32'd5);
    idle(1);
    idle(1);
    chk("clr_sum", 64'(bus.acc_out), 64'd20);
    idle(1);

    for (int k = 1; k <= 4; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) idle(1);
      feed(32'(k));
    end
    idle(1);
    chk("bub_lat1", 64'(bus.acc_valid), 64'd0);
    idle(1);
    chk("bub_lat2", 64'(bus.acc_valid), 64'd1);
    chk("bub_sum", 64'(bus.acc_out), 64'd10);
    idle(1);

    feed(32'd3);
    feed(32'd3);
    cycle(1, 0, 0, '0, 0);
    lit_reset("rst_mid");
    for (int k = 0; k < 4; k++) feed(32'd1);
    idle(1);
    idle(1);
    chk("rst_next", 64'(bus.acc_out), 64'd4);
    idle(1);

    for (int k = 0; k < 4; k++) feed(32'd6);
    idle(0);
    idle(0);
    chk("done_sum", 64'(bus.acc_out), 64'd24);
    cycle(1, 0, 0, '0, 0);
    lit_reset("rst_done");

    for (int i = 0; i < 3000; i++) begin
      bit r, c, pv, ar;
      logic [31:0] p;
      r  = ($urandom_range(0, 499) == 0);
      c  = ($urandom_range(0, 49) == 0);
      pv = ($urandom_range(0, 9) < 7);
      ar = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0)
        p = 32'hFFFF_FFFF - $urandom_range(0, 255);
      else
        p = $urandom;
      cycle(r, c, pv, p, ar);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
